// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 width codes, FSM state encoding
// and the access-size / alignment helpers used by the top and the lane aligner.
package load_store_unit_pkg;

  // Load funct3 codes
  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  // Store funct3 codes
  localparam logic [2:0] Funct3Sb = 3'b000;
  localparam logic [2:0] Funct3Sh = 3'b001;
  localparam logic [2:0] Funct3Sw = 3'b010;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StWaitR = 2'd2,
    StDone  = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    SizeByte = 2'd0,
    SizeHalf = 2'd1,
    SizeWord = 2'd2
  } access_size_e;

  // Unlisted funct3 codes fall back to a word access for both loads and stores.
  function automatic access_size_e access_size(input logic is_load, input logic [2:0] funct3);
    access_size_e sz;
    sz = SizeWord;
    if (is_load) begin
      case (funct3)
        Funct3Lb, Funct3Lbu: sz = SizeByte;
        Funct3Lh, Funct3Lhu: sz = SizeHalf;
        default:             sz = SizeWord;
      endcase
    end else begin
      case (funct3)
        Funct3Sb: sz = SizeByte;
        Funct3Sh: sz = SizeHalf;
        default:  sz = SizeWord;
      endcase
    end
    return sz;
  endfunction

  function automatic logic is_misaligned(input access_size_e sz, input logic [1:0] off);
    return ((sz == SizeHalf) && off[0]) || ((sz == SizeWord) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
//   req/we/addr/wdata/wmask : request fields, held while req is high until gnt
//   gnt                     : request accepted this cycle
//   rvalid/rdata            : read response
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, wdata, wmask, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, wmask, output gnt, rvalid, rdata);
endinterface

// File: rtl/load_store_unit_load_align.sv
// Combinational byte-lane logic shared by the load and store paths.
//   rdata_in/byte_off_in/funct3_in -> load_result_out (aligned, sign/zero-extended)
//   store_data_in/byte_off_in/funct3_in -> store_wdata_out (lane-replicated), store_wmask_out
module load_store_unit_load_align
  import load_store_unit_pkg::*;
(
  input  logic [31:0] rdata_in,
  input  logic [31:0] store_data_in,
  input  logic [1:0]  byte_off_in,
  input  logic [2:0]  funct3_in,
  output logic [31:0] load_result_out,
  output logic [31:0] store_wdata_out,
  output logic [3:0]  store_wmask_out
);

  logic [31:0] lane_shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign lane_shifted = rdata_in >> {byte_off_in, 3'b000};
  assign byte_sel     = lane_shifted[7:0];
  assign half_sel     = byte_off_in[1] ? rdata_in[31:16] : rdata_in[15:0];

  always_comb begin
    case (funct3_in)
      Funct3Lb:  load_result_out = {{24{byte_sel[7]}}, byte_sel};
      Funct3Lbu: load_result_out = {24'h0, byte_sel};
      Funct3Lh:  load_result_out = {{16{half_sel[15]}}, half_sel};
      Funct3Lhu: load_result_out = {16'h0, half_sel};
      default:   load_result_out = rdata_in;
    endcase
  end

  always_comb begin
    store_wdata_out = store_data_in;
    store_wmask_out = 4'hF;
    case (access_size(1'b0, funct3_in))
      SizeByte: begin
        store_wdata_out = {4{store_data_in[7:0]}};
        store_wmask_out = 4'b0001 << byte_off_in;
      end
      SizeHalf: begin
        store_wdata_out = {2{store_data_in[15:0]}};
        store_wmask_out = 4'b0011 << {byte_off_in[1], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage of the RV32I core: issues data-memory requests, stalls the pipeline while an
// access is in flight, aligns/extends load data and flags misaligned accesses and timeouts.
//   clk_in, rst_in (async, active high)
//   ls_valid_in/ls_is_load_in/funct3_in/addr_in/store_data_in : memory op from the pipeline
//   dmem                     : data-memory bus (master side)
//   lu_output_out/lu_valid_out : load result and its 1-cycle valid pulse
//   ls_stall_out             : hold upstream pipeline
//   misaligned_out/bus_err_out : 1-cycle error pulses
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     ls_valid_in,
  input  logic                     ls_is_load_in,
  input  logic [2:0]               funct3_in,
  input  logic [31:0]              addr_in,
  input  logic [31:0]              store_data_in,
  load_store_unit_if.master        dmem,
  output logic [31:0]              lu_output_out,
  output logic                     lu_valid_out,
  output logic                     ls_stall_out,
  output logic                     misaligned_out,
  output logic                     bus_err_out
);

  lsu_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        is_load_q, is_load_d;
  logic [31:0] data_q, data_d;
  logic [31:0] result_q, result_d;
  logic        lu_valid_q, lu_valid_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;

  logic [31:0] ld_result;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        timeout;

  // Both lane paths work from the captured op, so bus fields stay stable while stalled.
  load_store_unit_load_align u_align (
    .rdata_in        (dmem.rdata),
    .store_data_in   (data_q),
    .byte_off_in     (off_q),
    .funct3_in       (funct3_q),
    .load_result_out (ld_result),
    .store_wdata_out (st_wdata),
    .store_wmask_out (st_wmask)
  );

  // Last in-flight cycle: if the op does not complete now, it times out.
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    addr_d     = addr_q;
    off_d      = off_q;
    funct3_d   = funct3_q;
    is_load_d  = is_load_q;
    data_d     = data_q;
    result_d   = result_q;
    lu_valid_d = 1'b0;
    mis_d      = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ls_valid_in) begin
          addr_d    = {addr_in[31:2], 2'b00};
          off_d     = addr_in[1:0];
          funct3_d  = funct3_in;
          is_load_d = ls_is_load_in;
          data_d    = store_data_in;
          if (is_misaligned(access_size(ls_is_load_in, funct3_in), addr_in[1:0])) begin
            mis_d   = 1'b1;
            state_d = StDone;
          end else begin
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = StReq;
          end
        end
      end
      StReq: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.gnt && (!is_load_q || dmem.rvalid)) begin
          // Store accepted, or load granted with same-cycle read data.
          req_d   = 1'b0;
          state_d = StDone;
          if (is_load_q) begin
            result_d   = ld_result;
            lu_valid_d = 1'b1;
          end
        end else if (timeout) begin
          req_d    = 1'b0;
          err_d    = 1'b1;
          result_d = '0;
          state_d  = StDone;
        end else if (dmem.gnt) begin
          req_d   = 1'b0;
          state_d = StWaitR;
        end
      end
      StWaitR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem.rvalid) begin
          result_d   = ld_result;
          lu_valid_d = 1'b1;
          state_d    = StDone;
        end else if (timeout) begin
          err_d    = 1'b1;
          result_d = '0;
          state_d  = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      off_q      <= '0;
      funct3_q   <= '0;
      is_load_q  <= 1'b0;
      data_q     <= '0;
      result_q   <= '0;
      lu_valid_q <= 1'b0;
      mis_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      off_q      <= off_d;
      funct3_q   <= funct3_d;
      is_load_q  <= is_load_d;
      data_q     <= data_d;
      result_q   <= result_d;
      lu_valid_q <= lu_valid_d;
      mis_q      <= mis_d;
      err_q      <= err_d;
    end
  end

  assign dmem.req   = req_q;
  assign dmem.we    = req_q & ~is_load_q;
  assign dmem.addr  = addr_q;
  assign dmem.wdata = st_wdata;
  assign dmem.wmask = (req_q && !is_load_q) ? st_wmask : 4'h0;

  assign lu_output_out  = result_q;
  assign lu_valid_out   = lu_valid_q;
  assign misaligned_out = mis_q;
  assign bus_err_out    = err_q;
  assign ls_stall_out   = (state_q == StReq) || (state_q == StWaitR) ||
                          ((state_q == StIdle) && ls_valid_in);

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a transaction-level timeline model predicts every output per cycle
// from the op and the memory's gnt/rvalid delays; directed ops pin the model with literals.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ls_is_load;
  logic [2:0]  funct3;
  logic [31:0] addr, sdata;
  logic [31:0] lu_output;
  logic        lu_valid, stall, mis, berr;

  always #5 clk = ~clk;

  load_store_unit_if dmem_bus ();

  load_store_unit #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .ls_valid_in    (ls_valid),
    .ls_is_load_in  (ls_is_load),
    .funct3_in      (funct3),
    .addr_in        (addr),
    .store_data_in  (sdata),
    .dmem           (dmem_bus),
    .lu_output_out  (lu_output),
    .lu_valid_out   (lu_valid),
    .ls_stall_out   (stall),
    .misaligned_out (mis),
    .bus_err_out    (berr)
  );

  typedef struct {
    bit          ld;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] rd;
    int          g;    // cycles req is held before gnt
    int          r;    // cycles from gnt to rvalid
    int          gap;  // idle cycles after the op
  } op_t;

  int n_vec, n_fail;
  bit chk_en;
  logic        exp_req, exp_stall, exp_luv, exp_mis, exp_err, exp_we;
  logic [31:0] exp_out, exp_addr, exp_wdata;
  logic [3:0]  exp_wmask;
  logic [31:0] cur_out;

  int          obs_luv_t, obs_err_t, obs_mis_t, obs_stall_cnt, obs_req_cnt, obs_luv_cnt;
  logic [31:0] obs_out_end, obs_wdata, obs_addr;
  logic [3:0]  obs_wmask;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dmem_req", 32'(dmem_bus.req), 32'(exp_req));
      chk("ls_stall", 32'(stall), 32'(exp_stall));
      chk("lu_valid", 32'(lu_valid), 32'(exp_luv));
      chk("misaligned", 32'(mis), 32'(exp_mis));
      chk("bus_err", 32'(berr), 32'(exp_err));
      chk("lu_output", lu_output, exp_out);
      if (exp_req) begin
        chk("dmem_addr", dmem_bus.addr, exp_addr);
        chk("dmem_we", 32'(dmem_bus.we), 32'(exp_we));
        chk("dmem_wmask", 32'(dmem_bus.wmask), 32'(exp_wmask));
        if (exp_we) chk("dmem_wdata", dmem_bus.wdata, exp_wdata);
      end
    end
  end

  // Access size in bytes.
  function automatic int acc_size(input bit ld, input logic [2:0] f3);
    if (ld) return (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
    return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
    h = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd4:    return b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] model_wmask(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    sz = acc_size(1'b0, f3);
    if (sz == 1) return 4'(4'b0001 << int'(a[1:0]));
    if (sz == 2) return 4'(4'b0011 << (2 * int'(a[1])));
    return 4'hF;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    int sz;
    sz = acc_size(1'b0, f3);
    if (sz == 1) return {4{d[7:0]}};
    if (sz == 2) return {2{d[15:0]}};
    return d;
  endfunction

  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp_req = 0; exp_stall = 0; exp_luv = 0; exp_mis = 0; exp_err = 0; exp_we = 0;
    exp_addr = 0; exp_wdata = 0; exp_wmask = 0;
  endtask

  // Timeline of one op relative to its accept cycle t=0: completion cycle D, then gap idles.
  task automatic run_op(input op_t op);
    bit mis_m, ok;
    int d_cyc;
    logic [31:0] new_out;
    mis_m   = (int'(op.a[1:0]) % acc_size(op.ld, op.f3)) != 0;
    new_out = cur_out;
    if (mis_m) begin
      ok = 1; d_cyc = 1;
    end else if (op.ld) begin
      ok = (op.g + op.r + 1) <= 16; d_cyc = ok ? 2 + op.g + op.r : 17;
    end else begin
      ok = (op.g + 1) <= 16; d_cyc = ok ? 2 + op.g : 17;
    end
    if (!mis_m && !ok) new_out = 32'h0;
    else if (!mis_m && op.ld) new_out = model_load(op.f3, op.a, op.rd);
    obs_luv_t = -1; obs_err_t = -1; obs_mis_t = -1;
    obs_stall_cnt = 0; obs_req_cnt = 0; obs_luv_cnt = 0;
    obs_wmask = 'x; obs_wdata = 'x; obs_addr = 'x;
    for (int t = 0; t <= d_cyc + op.gap; t++) begin
      ls_valid = (t <= d_cyc);
      if (t <= d_cyc) begin
        ls_is_load = op.ld; funct3 = op.f3; addr = op.a; sdata = op.d;
      end else begin
        ls_is_load = 1'($urandom); funct3 = 3'($urandom); addr = $urandom; sdata = $urandom;
      end
      dmem_bus.gnt = !mis_m && (t == 1 + op.g);
      if (!mis_m && op.ld && (t == 1 + op.g + op.r)) begin
        dmem_bus.rvalid = 1'b1; dmem_bus.rdata = op.rd;
      end else begin
        dmem_bus.rvalid = (t >= d_cyc) ? 1'($urandom) : 1'b0;
        dmem_bus.rdata  = $urandom;
      end
      exp_stall = (t < d_cyc);
      exp_req   = !mis_m && t >= 1 && t <= 1 + op.g && t <= 16;
      exp_addr  = {op.a[31:2], 2'b00};
      exp_we    = !op.ld;
      exp_wmask = op.ld ? 4'h0 : model_wmask(op.f3, op.a);
      exp_wdata = model_wdata(op.f3, op.d);
      exp_luv   = op.ld && !mis_m && ok && (t == d_cyc);
      exp_mis   = mis_m && (t == d_cyc);
      exp_err   = !mis_m && !ok && (t == d_cyc);
      exp_out   = (t >= d_cyc) ? new_out : cur_out;
      @(negedge clk);
      if (dmem_bus.req) begin
        if (obs_req_cnt == 0) begin
          obs_wmask = dmem_bus.wmask; obs_wdata = dmem_bus.wdata; obs_addr = dmem_bus.addr;
        end
        obs_req_cnt++;
      end
      if (stall) obs_stall_cnt++;
      if (lu_valid) begin obs_luv_cnt++; obs_luv_t = t; end
      if (berr) obs_err_t = t;
      if (mis) obs_mis_t = t;
      obs_out_end = lu_output;
      @(posedge clk);
      #1;
    end
    cur_out = new_out;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    op_t op;
    int  seen;
    n_vec = 0; n_fail = 0; chk_en = 0; cur_out = 0;
    rst = 1; ls_valid = 0; ls_is_load = 0; funct3 = 0; addr = 0; sdata = 0;
    dmem_bus.gnt = 0; dmem_bus.rvalid = 0; dmem_bus.rdata = 0;
    clear_exp(); exp_out = 0;
    chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_lu_output", lu_output, 32'h0);
    chk("reset_dmem_addr", dmem_bus.addr, 32'h0);
    chk("reset_dmem_wdata", dmem_bus.wdata, 32'h0);
    chk("reset_dmem_wmask", 32'(dmem_bus.wmask), 32'h0);
    chk("reset_dmem_we", 32'(dmem_bus.we), 32'h0);
    rst = 0;
    @(posedge clk);
    #1;

    // LW 0x100, gnt with req, rvalid one cycle later.
    run_op('{1'b1, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 1, 1});
    chk("lw_valid_cycle", obs_luv_t, 3);
    chk("lw_value", obs_out_end, 32'hDEADBEEF);
    chk("lw_stall_cycles", obs_stall_cnt, 3);

    run_op('{1'b1, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0});
    chk("lb_value", obs_out_end, 32'hFFFF_FF80);
    chk("lb_same_cycle_rvalid", obs_luv_t, 2);
    run_op('{1'b1, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 0});
    chk("lbu_value", obs_out_end, 32'h0000_0080);
    run_op('{1'b1, 3'b001, 32'h102, 32'h0, 32'h80FF_1234, 0, 0, 1});
    chk("lh_value", obs_out_end, 32'hFFFF_80FF);

    run_op('{1'b0, 3'b000, 32'h201, 32'hAB, 32'h0, 1, 0, 1});
    chk("sb_wmask", 32'(obs_wmask), 32'h2);
    chk("sb_wdata", obs_wdata, 32'hABAB_ABAB);
    chk("sb_addr", obs_addr, 32'h200);
    chk("sb_no_lu_valid", obs_luv_cnt, 0);

    run_op('{1'b1, 3'b010, 32'h102, 32'h0, 32'h0, 0, 0, 1});
    chk("mis_no_req", obs_req_cnt, 0);
    chk("mis_pulse_cycle", obs_mis_t, 1);
    chk("mis_stall_cycles", obs_stall_cnt, 1);

    // gnt withheld past the timeout; late gnt/rvalid at +20 must be ignored.
    run_op('{1'b1, 3'b010, 32'h100, 32'h0, 32'h1234_5678, 19, 0, 5});
    chk("timeout_err_cycle", obs_err_t, 17);
    chk("timeout_output", obs_out_end, 32'h0);
    chk("timeout_no_lu_valid", obs_luv_cnt, 0);
    chk("timeout_req_cycles", obs_req_cnt, 16);

    // Exactly 16 in-flight cycles completes; 17 times out.
    run_op('{1'b1, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 5, 10, 0});
    chk("edge_load_ok_cycle", obs_luv_t, 17);
    run_op('{1'b1, 3'b010, 32'h400, 32'h0, 32'hCAFE_F00D, 5, 11, 0});
    chk("edge_load_err_cycle", obs_err_t, 17);
    run_op('{1'b0, 3'b010, 32'h404, 32'h5555_AAAA, 32'h0, 15, 0, 0});
    chk("edge_store_no_err", obs_err_t, -1);

    // Reset while waiting for read data.
    clear_exp();
    ls_valid = 1; ls_is_load = 1; funct3 = 3'b010; addr = 32'h300; sdata = 0;
    dmem_bus.gnt = 0; dmem_bus.rvalid = 0;
    exp_stall = 1; exp_out = cur_out;
    step();
    dmem_bus.gnt = 1; exp_req = 1; exp_addr = 32'h300; exp_we = 0; exp_wmask = 0;
    step();
    dmem_bus.gnt = 0; exp_req = 0;
    step();
    rst = 1; ls_valid = 0; clear_exp(); exp_out = 0; cur_out = 0;
    #1;
    chk("rst_mid_stall", 32'(stall), 32'h0);
    chk("rst_mid_req", 32'(dmem_bus.req), 32'h0);
    chk("rst_mid_output", lu_output, 32'h0);
    repeat (2) step();
    rst = 0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      dmem_bus.rvalid = (i == 0); dmem_bus.rdata = $urandom;
      @(negedge clk);
      if (lu_valid) seen++;
      @(posedge clk);
      #1;
    end
    dmem_bus.rvalid = 0;
    chk("rst_late_rvalid_ignored", seen, 0);

    for (int k = 0; k < 200; k++) begin
      op.ld = 1'($urandom);
      op.f3 = 3'($urandom);
      op.a  = $urandom;
      if ($urandom_range(0, 1) == 1) op.a[1:0] = 2'b00;
      op.d   = $urandom;
      op.rd  = $urandom;
      op.g   = ($urandom_range(0, 4) == 0) ? $urandom_range(12, 18) : $urandom_range(0, 2);
      op.r   = ($urandom_range(0, 4) == 0) ? $urandom_range(8, 16) : $urandom_range(0, 2);
      op.gap = $urandom_range(0, 2);
      run_op(op);
    end
    ls_valid = 0;
    clear_exp();
    exp_out = cur_out;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
